// File: rtl/mode_ctrl.sv
// mode_ctrl: two push-buttons -> debounced levels and a one-cycle
// increment/decrement command with hold-to-repeat.  Pressing both
// buttons locks the command output at hold until both are released.

// Per-button synchronizer and debouncer.
module mode_ctrl_db #(
  parameter int DB_CNT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic lvl
);

  localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic           meta_r;
  logic           sync_r;
  logic           lvl_r;
  logic [DBW-1:0] cnt_r;

  // Two-stage synchronizer, then a mismatch counter that must run for
  // DB_CNT consecutive cycles before the debounced level follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      lvl_r  <= 1'b0;
      cnt_r  <= {DBW{1'b0}};
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      if (sync_r != lvl_r) begin
        if (cnt_r == DBW'(DB_CNT - 1)) begin
          lvl_r <= sync_r;
          cnt_r <= {DBW{1'b0}};
        end else begin
          lvl_r <= lvl_r;
          cnt_r <= cnt_r + DBW'(1'b1);
        end
      end else begin
        lvl_r <= lvl_r;
        cnt_r <= {DBW{1'b0}};
      end
    end
  end

  assign lvl = lvl_r;

endmodule

module mode_ctrl #(
  parameter int DB_CNT  = 1000,
  parameter int REP_DLY = 50000,
  parameter int REP_PER = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [1:0] mode,
  output logic       up_lvl,
  output logic       dn_lvl
);

  localparam int TMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP_WAIT = 3'd1,
    UP_REP  = 3'd2,
    DN_WAIT = 3'd3,
    DN_REP  = 3'd4,
    LOCK    = 3'd5
  } state_t;

  logic          up_lvl_s;
  logic          dn_lvl_s;
  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [1:0]    mode_r;

  mode_ctrl_db #(.DB_CNT(DB_CNT)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_up),
    .lvl   (up_lvl_s)
  );

  mode_ctrl_db #(.DB_CNT(DB_CNT)) u_db_dn (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_dn),
    .lvl   (dn_lvl_s)
  );

  // Command FSM: first pulse on press, repeat after REP_DLY then every
  // REP_PER; release beats timer expiry, second button forces LOCK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      timer_r <= {TW{1'b0}};
      mode_r  <= MODE_HOLD;
    end else begin
      mode_r <= MODE_HOLD;
      case (state_r)
        IDLE: begin
          timer_r <= {TW{1'b0}};
          if (up_lvl_s && dn_lvl_s) begin
            state_r <= LOCK;
          end else if (up_lvl_s) begin
            mode_r  <= MODE_INC;
            state_r <= UP_WAIT;
          end else if (dn_lvl_s) begin
            mode_r  <= MODE_DEC;
            state_r <= DN_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        UP_WAIT, UP_REP: begin
          if (!up_lvl_s) begin
            state_r <= IDLE;
            timer_r <= {TW{1'b0}};
          end else if (dn_lvl_s) begin
            state_r <= LOCK;
            timer_r <= {TW{1'b0}};
          end else if ((state_r == UP_WAIT && timer_r == TW'(REP_DLY - 1)) ||
                       (state_r == UP_REP  && timer_r == TW'(REP_PER - 1))) begin
            mode_r  <= MODE_INC;
            state_r <= UP_REP;
            timer_r <= {TW{1'b0}};
          end else begin
            state_r <= state_r;
            timer_r <= timer_r + TW'(1'b1);
          end
        end
        DN_WAIT, DN_REP: begin
          if (!dn_lvl_s) begin
            state_r <= IDLE;
            timer_r <= {TW{1'b0}};
          end else if (up_lvl_s) begin
            state_r <= LOCK;
            timer_r <= {TW{1'b0}};
          end else if ((state_r == DN_WAIT && timer_r == TW'(REP_DLY - 1)) ||
                       (state_r == DN_REP  && timer_r == TW'(REP_PER - 1))) begin
            mode_r  <= MODE_DEC;
            state_r <= DN_REP;
            timer_r <= {TW{1'b0}};
          end else begin
            state_r <= state_r;
            timer_r <= timer_r + TW'(1'b1);
          end
        end
        LOCK: begin
          timer_r <= {TW{1'b0}};
          if (!up_lvl_s && !dn_lvl_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= LOCK;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign mode   = mode_r;
  assign up_lvl = up_lvl_s;
  assign dn_lvl = dn_lvl_s;

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl (DB_CNT=4, REP_DLY=20, REP_PER=5).
// Stimulus steps a reference model and queues the expected outputs; a
// monitor pops one entry per cycle and compares against the DUT.
module tb_mode_ctrl;

  localparam int DB_CNT  = 4;
  localparam int REP_DLY = 20;
  localparam int REP_PER = 5;

  typedef struct packed {
    logic [1:0] mode;
    logic       up;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [1:0] mode;
  logic       up_lvl;
  logic       dn_lvl;

  int checks = 0;
  int failures = 0;
  int n_up = 0;
  int n_dn = 0;
  int cyc_no = 0;

  exp_t exp_q[$];

  // Reference model state: raw-input delay lines, recent synchronized
  // history, debounced levels, and who owns the command with time held.
  bit raw_u[$];
  bit raw_d[$];
  bit hist_u[$];
  bit hist_d[$];
  bit m_up, m_dn;
  int owner;   // 0 none, 1 up, 2 down, 3 locked
  int held;    // cycles since the first pulse of the current press

  mode_ctrl #(.DB_CNT(DB_CNT), .REP_DLY(REP_DLY), .REP_PER(REP_PER)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .mode   (mode),
    .up_lvl (up_lvl),
    .dn_lvl (dn_lvl)
  );

  always #5 clk = ~clk;

  function automatic bit all_differ(input bit h[$], input bit lvl);
    if (h.size() < DB_CNT) return 1'b0;
    foreach (h[i]) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit repeat_due(input int k);
    return (k == REP_DLY) || (k > REP_DLY && ((k - REP_DLY) % REP_PER) == 0);
  endfunction

  task automatic model_reset();
    raw_u = '{1'b0, 1'b0};
    raw_d = '{1'b0, 1'b0};
    hist_u.delete();
    hist_d.delete();
    m_up = 1'b0;
    m_dn = 1'b0;
    owner = 0;
    held = 0;
  endtask

  task automatic model_step(input logic u, input logic d, input logic r);
    exp_t e;
    bit su, sd;
    logic [1:0] pm;
    pm = 2'b00;
    if (!r) begin
      model_reset();
    end else begin
      su = raw_u.pop_front();
      raw_u.push_back(u);
      sd = raw_d.pop_front();
      raw_d.push_back(d);
      case (owner)
        0: begin
          if (m_up && m_dn) owner = 3;
          else if (m_up) begin pm = 2'b01; owner = 1; held = 0; end
          else if (m_dn) begin pm = 2'b10; owner = 2; held = 0; end
        end
        1: begin
          if (!m_up) owner = 0;
          else if (m_dn) owner = 3;
          else begin held++; if (repeat_due(held)) pm = 2'b01; end
        end
        2: begin
          if (!m_dn) owner = 0;
          else if (m_up) owner = 3;
          else begin held++; if (repeat_due(held)) pm = 2'b10; end
        end
        default: if (!m_up && !m_dn) owner = 0;
      endcase
      hist_u.push_back(su);
      if (hist_u.size() > DB_CNT) void'(hist_u.pop_front());
      hist_d.push_back(sd);
      if (hist_d.size() > DB_CNT) void'(hist_d.pop_front());
      if (all_differ(hist_u, m_up)) m_up = ~m_up;
      if (all_differ(hist_d, m_dn)) m_dn = ~m_dn;
    end
    e.mode = pm;
    e.up = m_up;
    e.dn = m_dn;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus; reset must clear outputs immediately.
  task automatic cyc(input logic u, input logic d, input logic r);
    @(negedge clk);
    btn_up = u;
    btn_dn = d;
    reset = r;
    model_step(u, d, r);
    if (!r) begin
      #1;
      checks++;
      if (mode !== 2'b00 || up_lvl !== 1'b0 || dn_lvl !== 1'b0) begin
        failures++;
        $display("FAIL reset_async t=%0t got mode=%b up=%b dn=%b required 00/0/0",
                 $time, mode, up_lvl, dn_lvl);
      end
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Monitor: compare each cycle's DUT outputs with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (mode == 2'b01) n_up++;
      if (mode == 2'b10) n_dn++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mode !== e.mode || up_lvl !== e.up || dn_lvl !== e.dn) begin
          failures++;
          $display("FAIL scoreboard cycle=%0d got mode=%b up=%b dn=%b required mode=%b up=%b dn=%b",
                   cyc_no, mode, up_lvl, dn_lvl, e.mode, e.up, e.dn);
        end
      end
    end
  end

  initial begin
    int b_up, b_dn;
    int len;
    logic u, d, uu, dd;
    bit glitchy;

    model_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);

    // Clean 10-cycle press: one increment pulse.
    b_up = n_up;
    repeat (10) cyc(1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    check_cnt("clean_press_pulses", n_up - b_up, 1);

    // Bouncing every 2 cycles never gets through the debouncer.
    b_up = n_up;
    repeat (8) begin
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    repeat (10) cyc(1'b0, 1'b0, 1'b1);
    check_cnt("bounce_pulses", n_up - b_up, 0);

    // Down held 40 cycles past first pulse: first, +20, +25 .. +40.
    b_dn = n_dn;
    repeat (41) cyc(1'b0, 1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    check_cnt("dn_repeat_pulses", n_dn - b_dn, 6);

    // Up then down 8 cycles later: one up pulse, then locked.
    b_up = n_up;
    b_dn = n_dn;
    repeat (8) cyc(1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, 1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    check_cnt("lock_up_pulses", n_up - b_up, 1);
    check_cnt("lock_dn_pulses", n_dn - b_dn, 0);

    // Both pressed together: no pulse at all.
    b_up = n_up;
    b_dn = n_dn;
    repeat (15) cyc(1'b1, 1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    check_cnt("both_same_cycle_pulses", (n_up - b_up) + (n_dn - b_dn), 0);

    // Reset during repeat with the button still held: new press afterwards.
    b_up = n_up;
    repeat (34) cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (15) cyc(1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    check_cnt("reset_midrep_pulses", n_up - b_up, 4);

    // Randomized segments with glitches and occasional resets.
    repeat (150) begin
      if ($urandom_range(0, 29) == 0) begin
        len = $urandom_range(1, 3);
        repeat (len) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
      end
      u = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 60);
      glitchy = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < len; i++) begin
        uu = u;
        dd = d;
        if (glitchy && $urandom_range(0, 3) == 0) uu = ~uu;
        if (glitchy && $urandom_range(0, 3) == 0) dd = ~dd;
        cyc(uu, dd, 1'b1);
      end
    end
    repeat (30) cyc(1'b0, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    check_cnt("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
